// File: rtl/pi_integrator_mc.sv
// Multi-channel trapezoidal PI integrator, one shared MAC.
// y[k] = sat(y[k-1] + A*x[k] + B*x[k-1]) per channel, anti-windup.
module pi_integrator_mc #(
   parameter int             N_CH        = 4,
   parameter int             W           = 32,
   parameter int             FRAC        = 16,
   parameter logic [W-1:0]   A           = 32'h0001_0800,
   parameter logic [W-1:0]   B           = 32'hFFFF_0800,
   parameter logic [W-1:0]   UPPER_LIMIT = 32'h0001_0000,
   parameter logic [W-1:0]   DOWN_LIMIT  = 32'hFFFF_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rst_user,
   input  logic              sta,
   input  logic              freeze,
   input  logic [N_CH*W-1:0] x,
   output logic [N_CH*W-1:0] y,
   output logic [N_CH-1:0]   sat_flags,
   output logic              busy,
   output logic              done_sig
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SW = W + 2;
   localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
   localparam logic signed [W-1:0] AS = A;
   localparam logic signed [W-1:0] BS = B;
   localparam logic signed [SW-1:0] UL = SW'($signed(UPPER_LIMIT));
   localparam logic signed [SW-1:0] DL = SW'($signed(DOWN_LIMIT));
   localparam logic signed [2*W:0] HALF = (2*W+1)'(1) << (FRAC - 1);

   typedef enum logic [2:0] {IDLE, MUL, ADD, SAT, DONE} state_t;

   state_t st, nxt;
   logic [CW-1:0] c;
   logic frz;
   logic signed [W-1:0] x_lat [N_CH];
   logic signed [W-1:0] x_prev [N_CH];
   logic signed [W-1:0] y_state [N_CH];
   logic signed [2*W-1:0] pa, pb;
   logic signed [SW-1:0] s, v;

   function automatic logic signed [SW-1:0] rnd(
      input logic signed [2*W-1:0] p
   );
      logic signed [2*W:0] t;
      t = {p[2*W-1], p};
      t = t + HALF;
      return SW'(t >>> FRAC);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= nxt;
   end

   always_comb begin
      nxt = st;
      unique case (st)
         IDLE:    if (sta) nxt = MUL;
         MUL:     nxt = ADD;
         ADD:     nxt = SAT;
         SAT:     nxt = (c == LAST) ? DONE : MUL;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (rst_user) nxt = IDLE;
   end

   always_comb begin
      v = s;
      if (s > UL)      v = UL;
      else if (s < DL) v = DL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c         <= '0;
         frz       <= 1'b0;
         pa        <= '0;
         pb        <= '0;
         s         <= '0;
         sat_flags <= '0;
         for (int i = 0; i < N_CH; i++) begin
            x_lat[i]   <= '0;
            x_prev[i]  <= '0;
            y_state[i] <= '0;
         end
      end else if (rst_user) begin
         c         <= '0;
         sat_flags <= '0;
         for (int i = 0; i < N_CH; i++) begin
            x_prev[i]  <= '0;
            y_state[i] <= '0;
         end
      end else begin
         case (st)
            IDLE: if (sta) begin
               c   <= '0;
               frz <= freeze;
               for (int i = 0; i < N_CH; i++)
                  x_lat[i] <= x[i*W +: W];
            end
            MUL: begin
               pa <= (2*W)'(AS) * (2*W)'(x_lat[c]);
               pb <= (2*W)'(BS) * (2*W)'(x_prev[c]);
            end
            ADD: s <= SW'(y_state[c]) + rnd(pa) + rnd(pb);
            SAT: begin
               x_prev[c]    <= x_lat[c];
               sat_flags[c] <= (s != v);
               // frozen frames still track x and saturation
               if (!frz) y_state[c] <= v[W-1:0];
               if (c != LAST) c <= c + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      y = '0;
      for (int i = 0; i < N_CH; i++)
         y[i*W +: W] = y_state[i];
   end

   assign busy     = (st != IDLE);
   assign done_sig = (st == DONE);

endmodule
